atsc_dc_blocker: RTL and testbench

Streaming DC-offset remover that sits directly upstream of the AGC in the ATSC receive chain, between the FPLL output and the AGC input, in the `ce_clk` domain. It subtracts a running moving-average estimate of the DC level from each sc16 sample. The estimate covers the last 2^LOG2_LEN samples. The block uses AXI-stream handshakes on both sides and is throughput-1, so the AGC receives a zero-mean stream.

---
 rtl/atsc_rx_pkg.sv | 28 ++
 rtl/atsc_dc_blocker_ram.sv | 27 ++
 rtl/atsc_dc_blocker.sv | 157 +++++++++++++++
 tb/tb_atsc_dc_blocker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atsc_rx_pkg.sv
// Shared ATSC receive-chain types: sc16 packing, sample widths and the
// saturating narrow used by the DC blocker and the AGC-side blocks.
package atsc_rx_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int LOG2_LEN_MAX = 12;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] i;
        logic signed [SAMPLE_W-1:0] q;
    } sc16_t;

    typedef enum logic {
        FILL,
        RUN
    } dcState_e;

    // Clamp a 17-bit difference into the signed 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] v);
        if (v > 17'sd32767)
            return 16'sh7FFF;
        else if (v < -17'sd32768)
            return 16'sh8000;
        else
            return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/atsc_dc_blocker_ram.sv
// Simple dual-port read-first ring RAM for the DC blocker history window.
module atsc_dc_blocker_ram
    import atsc_rx_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 2 * SAMPLE_W
) (
    input  logic              clk_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [DATA_W-1:0] rdData_o
);

    logic [DATA_W-1:0] mem_q [1 << ADDR_W];

    // Same-address read returns the entry being overwritten this cycle.
    always_ff @(posedge clk_i) begin
        if (rdEn_i)
            rdData_o <= mem_q[rdAddr_i];
        if (wrEn_i)
            mem_q[wrAddr_i] <= wrData_i;
    end

endmodule

// File: rtl/atsc_dc_blocker.sv
// Moving-average DC remover for sc16 AXI streams, two-stage pipeline.
// Define ATSC_DC_BLOCKER_BYPASS_EN to add a 'bypass' input passing samples through unmodified.
module atsc_dc_blocker
    import atsc_rx_pkg::*;
#(
    parameter int LOG2_LEN = 10
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic [31:0] in_tdata,
    input  logic        in_tvalid,
    input  logic        in_tlast,
    output logic        in_tready,
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    output logic        out_tlast,
    input  logic        out_tready,
    input  logic        clear,
`ifdef ATSC_DC_BLOCKER_BYPASS_EN
    input  logic        bypass,
`endif
    output logic [15:0] dc_i,
    output logic [15:0] dc_q
);

    localparam int N     = 1 << LOG2_LEN;
    localparam int SUM_W = SAMPLE_W + LOG2_LEN;

    logic                    en;
    logic                    accept;
    logic                    bypassNow;
    dcState_e                state_q;
    logic [LOG2_LEN-1:0]     wrPtr_q;
    logic [LOG2_LEN-1:0]     fillCnt_q;
    logic                    s1Valid_q;
    logic                    s1Last_q;
    logic                    s1Fill_q;
    sc16_t                   s1Data_q;
    sc16_t                   ramRd;
    sc16_t                   oldSample;
    logic signed [SUM_W-1:0] sumI_q, sumQ_q, sumI_d, sumQ_d;
    logic signed [SUM_W-1:0] sumNextI, sumNextQ;
    logic                    clrPend_q, clrPend_d;
    logic signed [15:0]      meanI, meanQ, yI, yQ;
    logic [31:0]             outData_d;
    logic                    outValid_q, outLast_q;
    logic [31:0]             outData_q;
    logic [15:0]             dcI_q, dcQ_q;

`ifdef ATSC_DC_BLOCKER_BYPASS_EN
    assign bypassNow = bypass;
`else
    assign bypassNow = 1'b0;
`endif

    assign en        = !outValid_q || out_tready;
    assign in_tready = en && !clear && !ce_rst;
    assign accept    = in_tvalid && in_tready;

    atsc_dc_blocker_ram #(
        .ADDR_W(LOG2_LEN),
        .DATA_W(32)
    ) uRam (
        .clk_i   (ce_clk),
        .wrEn_i  (accept),
        .wrAddr_i(wrPtr_q),
        .wrData_i(in_tdata),
        .rdEn_i  (accept),
        .rdAddr_i(wrPtr_q),
        .rdData_o(ramRd)
    );

    // A clear that arrives while S1 is stalled is deferred so that sample still sees the old sum.
    always_comb begin
        oldSample = s1Fill_q ? '0 : ramRd;
        sumNextI  = sumI_q + SUM_W'(s1Data_q.i) - SUM_W'(oldSample.i);
        sumNextQ  = sumQ_q + SUM_W'(s1Data_q.q) - SUM_W'(oldSample.q);
        meanI     = SAMPLE_W'(sumNextI >>> LOG2_LEN);
        meanQ     = SAMPLE_W'(sumNextQ >>> LOG2_LEN);
        yI        = sat16(17'(s1Data_q.i) - 17'(meanI));
        yQ        = sat16(17'(s1Data_q.q) - 17'(meanQ));
        outData_d = bypassNow ? s1Data_q : {yI, yQ};
        sumI_d    = sumI_q;
        sumQ_d    = sumQ_q;
        clrPend_d = clrPend_q;
        if (en && s1Valid_q) begin
            sumI_d    = (clear || clrPend_q) ? '0 : sumNextI;
            sumQ_d    = (clear || clrPend_q) ? '0 : sumNextQ;
            clrPend_d = 1'b0;
        end else if (clear) begin
            if (s1Valid_q) begin
                clrPend_d = 1'b1;
            end else begin
                sumI_d = '0;
                sumQ_d = '0;
            end
        end
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst || clear) begin
            state_q   <= FILL;
            wrPtr_q   <= '0;
            fillCnt_q <= '0;
        end else if (accept) begin
            wrPtr_q <= wrPtr_q + LOG2_LEN'(1);
            if (state_q == FILL) begin
                fillCnt_q <= fillCnt_q + LOG2_LEN'(1);
                if (fillCnt_q == LOG2_LEN'(N - 1))
                    state_q <= RUN;
            end
        end
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            s1Valid_q  <= 1'b0;
            s1Last_q   <= 1'b0;
            s1Fill_q   <= 1'b0;
            s1Data_q   <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outData_q  <= '0;
            dcI_q      <= '0;
            dcQ_q      <= '0;
            sumI_q     <= '0;
            sumQ_q     <= '0;
            clrPend_q  <= 1'b0;
        end else begin
            sumI_q    <= sumI_d;
            sumQ_q    <= sumQ_d;
            clrPend_q <= clrPend_d;
            if (en) begin
                s1Valid_q <= accept;
                if (accept) begin
                    s1Data_q <= in_tdata;
                    s1Last_q <= in_tlast;
                    s1Fill_q <= (state_q == FILL);
                end
                outValid_q <= s1Valid_q;
                outLast_q  <= s1Valid_q && s1Last_q;
                if (s1Valid_q) begin
                    outData_q <= outData_d;
                    dcI_q     <= meanI;
                    dcQ_q     <= meanQ;
                end
            end
        end
    end

    assign out_tvalid = outValid_q;
    assign out_tlast  = outLast_q;
    assign out_tdata  = outData_q;
    assign dc_i       = dcI_q;
    assign dc_q       = dcQ_q;

endmodule

// File: tb/tb_atsc_dc_blocker.sv
// Randomized self-checking bench for atsc_dc_blocker against a sliding-window
// average model of the last N accepted samples.
module tb_atsc_dc_blocker;

    localparam int L = 4;
    localparam int N = 1 << L;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inData = '0;
    logic        inValid = 1'b0;
    logic        inLast = 1'b0;
    logic        inReady;
    logic [31:0] outData;
    logic        outValid;
    logic        outLast;
    logic        outReady = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] dcI, dcQ;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit latencyOn = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [15:0] dcI;
        logic [15:0] dcQ;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   histI[$];
    int   histQ[$];

    atsc_dc_blocker #(.LOG2_LEN(L)) dut (
        .ce_clk    (clk),
        .ce_rst    (rst),
        .in_tdata  (inData),
        .in_tvalid (inValid),
        .in_tlast  (inLast),
        .in_tready (inReady),
        .out_tdata (outData),
        .out_tvalid(outValid),
        .out_tlast (outLast),
        .out_tready(outReady),
        .clear     (clear),
        .dc_i      (dcI),
        .dc_q      (dcQ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Floor of the window sum over N; missing history during fill counts as zero.
    function automatic int windowMean(input int h[$]);
        int s = 0;
        foreach (h[k]) s += h[k];
        if (s >= 0 || (s % N) == 0)
            return s / N;
        return s / N - 1;
    endfunction

    function automatic logic [15:0] satSub(input int x, input int m);
        int d = x - m;
        if (d > 32767)
            d = 32767;
        else if (d < -32768)
            d = -32768;
        return d[15:0];
    endfunction

    task automatic modelAccept();
        exp_t e;
        int xi = int'($signed(inData[31:16]));
        int xq = int'($signed(inData[15:0]));
        int mi, mq;
        histI.push_back(xi);
        histQ.push_back(xq);
        if (histI.size() > N) void'(histI.pop_front());
        if (histQ.size() > N) void'(histQ.pop_front());
        mi = windowMean(histI);
        mq = windowMean(histQ);
        e.data = {satSub(xi, mi), satSub(xq, mq)};
        e.last = inLast;
        e.dcI  = mi[15:0];
        e.dcQ  = mq[15:0];
        e.cyc  = cyc;
        expQ.push_back(e);
    endtask

    // Handshakes are observed mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            histI.delete();
            histQ.delete();
        end else begin
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious", 32'(outValid), 32'd0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("data", outData, monE.data);
                    checkOutput("last", 32'(outLast), 32'(monE.last));
                    checkOutput("dcI", 32'(dcI), 32'(monE.dcI));
                    checkOutput("dcQ", 32'(dcQ), 32'(monE.dcQ));
                    if (latencyOn)
                        checkOutput("latency", 32'(cyc - monE.cyc), 32'd2);
                end
            end
            if (inValid && inReady)
                modelAccept();
            if (clear) begin
                histI.delete();
                histQ.delete();
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l,
                                 input logic r, input logic c);
        @(posedge clk);
        #1;
        inValid  = v;
        inData   = d;
        inLast   = l;
        outReady = r;
        clear    = c;
        #1;
    endtask

    task automatic drainCheck(input string tag);
        for (int k = 0; k < 20 && expQ.size() > 0; k++)
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        inValid  = 1'b0;
        clear    = 1'b0;
        outReady = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(outValid), 32'd0);
        checkOutput("rstLast", 32'(outLast), 32'd0);
        checkOutput("rstReady", 32'(inReady), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("postRstReady", 32'(inReady), 32'd1);
    endtask

    task automatic runFill();
        latencyOn = 1'b1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, {16'd1000, 16'hFE0C}, 1'b0, 1'b1, 1'b0);
            if (i == 2)
                checkOutput("fillFirst", outData, {16'd938, 16'hFE2C});
            if (i == 18)
                checkOutput("fillSteady", outData, 32'd0);
        end
        drainCheck("fillDrain");
        checkOutput("fillDcI", 32'(dcI), 32'd1000);
        checkOutput("fillDcQ", 32'(dcQ), 32'h0000FE0C);
        latencyOn = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstTdata", outData, 32'd0);
        checkOutput("rstTvalid", 32'(outValid), 32'd0);
        checkOutput("rstInReady", 32'(inReady), 32'd0);
        checkOutput("rstDc", {dcI, dcQ}, 32'd0);
        rst      = 1'b0;
        outReady = 1'b0;
        #1;
        checkOutput("firstReady", 32'(inReady), 32'd1);

        runFill();

        doReset();
        for (int i = 0; i < 19; i++) begin
            d = (i < 16) ? {16'h8000, 16'd0} : {16'h7FFF, 16'd0};
            applyStimulus(i <= 16, d, 1'b0, 1'b1, 1'b0);
            if (i == 18)
                checkOutput("satI", 32'(outData[31:16]), 32'h7FFF);
        end
        drainCheck("satDrain");

        latencyOn = 1'b1;
        for (int i = 0; i < 35; i++)
            applyStimulus(1'b1, $urandom, (i % 7) == 6, 1'b1, 1'b0);
        drainCheck("tlastDrain");
        latencyOn = 1'b0;

        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0, !(i >= 5 && i <= 9), 1'b0);
            if (i == 8) begin
                checkOutput("bpInReady", 32'(inReady), 32'd0);
                checkOutput("bpHold", 32'(outValid), 32'd1);
            end
        end
        drainCheck("bpDrain");

        doReset();
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, {16'd1000, 16'd0}, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, {16'd1000, 16'd0}, 1'b0, 1'b1, 1'b1);
        checkOutput("clrReady", 32'(inReady), 32'd0);
        applyStimulus(1'b1, {16'd1000, 16'd0}, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("clrRestart", 32'(outData[31:16]), 32'd938);
        drainCheck("clrDrain");

        for (int i = 0; i < 400; i++) begin
            logic c;
            c = ($urandom_range(0, 29) == 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 3) != 0, c);
            if (c)
                checkOutput("rndClrReady", 32'(inReady), 32'd0);
        end
        drainCheck("rndDrain");

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        doReset();
        runFill();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
